// File: rtl/fifo_rd_drain_ctrl.sv
// Read-side drain sequencer for an async FIFO: pops one word at a time, presents it to a
// valid/ready consumer and inserts a programmable idle gap after each accepted word.
module fifo_rd_drain_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LAT     = 0,
    parameter int unsigned GAP_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_r_empty,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_r_inc,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    input  logic [GAP_WIDTH-1:0]  i_gap_cfg,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_word_cnt
);

    typedef enum logic [1:0] {StIdle, StFetch, StPresent, StGap} state_t;

    state_t                r_state;
    logic [GAP_WIDTH-1:0]  r_gap_cnt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_busy;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic                  w_pop;

    // Reset gating keeps the pop strobe quiet while the FSM is held in reset.
    assign w_pop   = (r_state == StIdle) && i_en && !i_r_empty && !i_rst;
    assign o_r_inc = w_pop;

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_word_cnt  = r_word_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_gap_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_busy <= 1'b1;
                        if (RD_LAT == 0) begin
                            r_out_data  <= i_rd_data;
                            r_out_valid <= 1'b1;
                            r_state     <= StPresent;
                        end else begin
                            r_state <= StFetch;
                        end
                    end
                end
                StFetch: begin
                    r_out_data  <= i_rd_data;
                    r_out_valid <= 1'b1;
                    r_state     <= StPresent;
                end
                StPresent: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_word_cnt  <= r_word_cnt + 1'b1;
                        if (i_gap_cfg == '0) begin
                            r_busy  <= 1'b0;
                            r_state <= StIdle;
                        end else begin
                            r_gap_cnt <= i_gap_cfg;
                            r_state   <= StGap;
                        end
                    end
                end
                StGap: begin
                    // Gap length was latched at the handshake; live GAP_CFG is ignored here.
                    r_gap_cnt <= r_gap_cnt - 1'b1;
                    if (r_gap_cnt == GAP_WIDTH'(1)) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain_ctrl.sv
// Directed bench for fifo_rd_drain_ctrl: one RD_LAT=0 instance with a narrow word counter
// and one RD_LAT=1 instance, each fed by a small FIFO model.
module tb_fifo_rd_drain_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] gap_cfg = 8'd0;

    // RD_LAT=0 instance, 4-bit counter so wrap is reachable quickly
    logic       en0 = 1'b0;
    logic       empty0;
    logic [7:0] rd_data0;
    logic       r_inc0;
    logic [7:0] out_data0;
    logic       valid0;
    logic       busy0;
    logic [3:0] cnt0;

    // RD_LAT=1 instance
    logic       en1 = 1'b0;
    logic       empty1;
    logic [7:0] rd_data1 = 8'hEE;
    logic       r_inc1;
    logic [7:0] out_data1;
    logic       valid1;
    logic       busy1;
    logic [15:0] cnt1;

    logic [7:0] mem0 [64];
    logic [7:0] mem1 [64];
    logic [5:0] wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fifo_rd_drain_ctrl #(.DATA_WIDTH(8), .RD_LAT(0), .GAP_WIDTH(8), .CNT_WIDTH(4)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en0), .i_r_empty(empty0), .i_rd_data(rd_data0),
        .o_r_inc(r_inc0), .o_out_data(out_data0), .o_out_valid(valid0),
        .i_out_ready(ready), .i_gap_cfg(gap_cfg), .o_busy(busy0), .o_word_cnt(cnt0)
    );

    fifo_rd_drain_ctrl #(.DATA_WIDTH(8), .RD_LAT(1), .GAP_WIDTH(8), .CNT_WIDTH(16)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en1), .i_r_empty(empty1), .i_rd_data(rd_data1),
        .o_r_inc(r_inc1), .o_out_data(out_data1), .o_out_valid(valid1),
        .i_out_ready(ready), .i_gap_cfg(gap_cfg), .o_busy(busy1), .o_word_cnt(cnt1)
    );

    // FIFO models: zero-latency head for dut0, registered head for dut1
    assign empty0   = (wp0 == rp0);
    assign rd_data0 = mem0[rp0];
    assign empty1   = (wp1 == rp1);

    always @(posedge clk) begin
        if (r_inc0) rp0 <= rp0 + 6'd1;
        if (r_inc1) begin
            rd_data1 <= mem1[rp1];
            rp1      <= rp1 + 6'd1;
        end else begin
            rd_data1 <= 8'hEE;
        end
    end

    task automatic push0(input logic [7:0] d);
        mem0[wp0] = d;
        wp0 = wp0 + 6'd1;
    endtask

    task automatic push1(input logic [7:0] d);
        mem1[wp1] = d;
        wp1 = wp1 + 6'd1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({r_inc0, valid0, busy0, cnt0, out_data0} !== 15'd0) begin
            bad++;
            $display("FAIL reset0: got inc=%b vld=%b busy=%b cnt=%0d data=%h, want all 0",
                     r_inc0, valid0, busy0, cnt0, out_data0);
        end
        total++;
        if ({r_inc1, valid1, busy1, cnt1, out_data1} !== 27'd0) begin
            bad++;
            $display("FAIL reset1: got inc=%b vld=%b busy=%b cnt=%0d data=%h, want all 0",
                     r_inc1, valid1, busy1, cnt1, out_data1);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_stream();
        logic [7:0] exp_inc = 8'b0001_0101;
        logic [7:0] exp_vld = 8'b0010_1010;
        logic [7:0] words [3];
        int k = 0;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        gap_cfg = 8'd0;
        ready = 1'b1;
        en0 = 1'b1;
        push0(8'h11); push0(8'h22); push0(8'h33);
        for (int c = 0; c < 8; c++) begin
            if (c != 0) next_cycle();
            #1;
            total++;
            if (r_inc0 !== exp_inc[c] || valid0 !== exp_vld[c] || busy0 !== exp_vld[c]) begin
                bad++;
                $display("FAIL stream c%0d: got inc=%b vld=%b busy=%b, want %b %b %b",
                         c, r_inc0, valid0, busy0, exp_inc[c], exp_vld[c], exp_vld[c]);
            end
            if (exp_vld[c]) begin
                total++;
                if (out_data0 !== words[k]) begin
                    bad++;
                    $display("FAIL stream_data c%0d: got %h want %h", c, out_data0, words[k]);
                end
                k++;
            end
        end
        total++;
        if (cnt0 !== 4'd3) begin
            bad++;
            $display("FAIL stream_cnt: got %0d want 3", cnt0);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        push0(8'hA5); push0(8'h5A);
        #1;
        total++;
        if (r_inc0 !== 1'b1) begin
            bad++;
            $display("FAIL bp_pop: got inc=%b want 1", r_inc0);
        end
        for (int c = 1; c <= 11; c++) begin
            next_cycle();
            if (c == 11) ready = 1'b1;
            #1;
            total++;
            if (valid0 !== 1'b1 || out_data0 !== 8'hA5 || r_inc0 !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold c%0d: got vld=%b data=%h inc=%b, want 1 a5 0",
                         c, valid0, out_data0, r_inc0);
            end
        end
        next_cycle();
        #1;
        total++;
        if (valid0 !== 1'b0 || r_inc0 !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept: got vld=%b inc=%b want 0 1", valid0, r_inc0);
        end
        next_cycle();
        #1;
        total++;
        if (valid0 !== 1'b1 || out_data0 !== 8'h5A) begin
            bad++;
            $display("FAIL bp_second: got vld=%b data=%h want 1 5a", valid0, out_data0);
        end
        next_cycle();
        #1;
        total++;
        if (cnt0 !== 4'd5) begin
            bad++;
            $display("FAIL bp_cnt: got %0d want 5", cnt0);
        end
        next_cycle();
    endtask

    task automatic test_gap();
        logic [7:0] exp_inc  = 8'b0010_0001;
        logic [7:0] exp_vld  = 8'b0100_0010;
        logic [7:0] exp_busy = 8'b0101_1110;
        gap_cfg = 8'd3;
        push0(8'h31); push0(8'h32);
        for (int c = 0; c < 8; c++) begin
            if (c != 0) next_cycle();
            if (c >= 2 && c <= 4) gap_cfg = 8'd7;
            if (c >= 5) gap_cfg = 8'd0;
            #1;
            total++;
            if (r_inc0 !== exp_inc[c] || valid0 !== exp_vld[c] || busy0 !== exp_busy[c]) begin
                bad++;
                $display("FAIL gap c%0d: got inc=%b vld=%b busy=%b, want %b %b %b",
                         c, r_inc0, valid0, busy0, exp_inc[c], exp_vld[c], exp_busy[c]);
            end
        end
        total++;
        if (cnt0 !== 4'd7) begin
            bad++;
            $display("FAIL gap_cnt: got %0d want 7", cnt0);
        end
        next_cycle();
    endtask

    task automatic test_en_drop();
        logic [7:0] exp_inc = 8'b0100_0001;
        logic [7:0] exp_vld = 8'b1000_0010;
        push0(8'h41); push0(8'h42);
        for (int c = 0; c < 8; c++) begin
            if (c != 0) next_cycle();
            en0 = (c == 0 || c >= 6);
            #1;
            total++;
            if (r_inc0 !== exp_inc[c] || valid0 !== exp_vld[c] || busy0 !== exp_vld[c]) begin
                bad++;
                $display("FAIL en_drop c%0d: got inc=%b vld=%b busy=%b, want %b %b %b",
                         c, r_inc0, valid0, busy0, exp_inc[c], exp_vld[c], exp_vld[c]);
            end
            if (c == 1 || c == 7) begin
                total++;
                if (out_data0 !== (c == 1 ? 8'h41 : 8'h42)) begin
                    bad++;
                    $display("FAIL en_drop_data c%0d: got %h", c, out_data0);
                end
            end
        end
        next_cycle();
        #1;
        total++;
        if (cnt0 !== 4'd9) begin
            bad++;
            $display("FAIL en_drop_cnt: got %0d want 9", cnt0);
        end
        next_cycle();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) push0(8'(8'h60 + i));
        repeat (14) next_cycle();
        #1;
        total++;
        if (cnt0 !== 4'hF) begin
            bad++;
            $display("FAIL wrap_ones: got %h want f", cnt0);
        end
        next_cycle();
        push0(8'h6F);
        repeat (3) next_cycle();
        #1;
        total++;
        if (cnt0 !== 4'h0) begin
            bad++;
            $display("FAIL wrap_zero: got %h want 0", cnt0);
        end
        next_cycle();
    endtask

    task automatic test_rd_lat1();
        logic [7:0] exp_inc  = 8'b0000_1001;
        logic [7:0] exp_vld  = 8'b0010_0100;
        logic [7:0] exp_busy = 8'b0011_0110;
        en0 = 1'b0;
        en1 = 1'b1;
        push1(8'h71); push1(8'h72);
        for (int c = 0; c < 8; c++) begin
            if (c != 0) next_cycle();
            #1;
            total++;
            if (r_inc1 !== exp_inc[c] || valid1 !== exp_vld[c] || busy1 !== exp_busy[c]) begin
                bad++;
                $display("FAIL lat1 c%0d: got inc=%b vld=%b busy=%b, want %b %b %b",
                         c, r_inc1, valid1, busy1, exp_inc[c], exp_vld[c], exp_busy[c]);
            end
            if (c == 2 || c == 5) begin
                total++;
                if (out_data1 !== (c == 2 ? 8'h71 : 8'h72)) begin
                    bad++;
                    $display("FAIL lat1_data c%0d: got %h", c, out_data1);
                end
            end
        end
        total++;
        if (cnt1 !== 16'd2) begin
            bad++;
            $display("FAIL lat1_cnt: got %0d want 2", cnt1);
        end
        en1 = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        en0 = 1'b1;
        push0(8'h99);
        next_cycle();
        push0(8'h9A);
        #1;
        total++;
        if (valid0 !== 1'b1 || out_data0 !== 8'h99) begin
            bad++;
            $display("FAIL rstmid_pre: got vld=%b data=%h want 1 99", valid0, out_data0);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({r_inc0, valid0, busy0, cnt0, out_data0} !== 15'd0 || cnt1 !== 16'd0) begin
            bad++;
            $display("FAIL rstmid: got inc=%b vld=%b busy=%b cnt=%0d data=%h cnt1=%0d, want 0",
                     r_inc0, valid0, busy0, cnt0, out_data0, cnt1);
        end
        next_cycle();
        rst = 1'b0;
        ready = 1'b1;
        #1;
        total++;
        if (r_inc0 !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_resume: got inc=%b want 1", r_inc0);
        end
        next_cycle();
        #1;
        total++;
        if (valid0 !== 1'b1 || out_data0 !== 8'h9A) begin
            bad++;
            $display("FAIL rstmid_word: got vld=%b data=%h want 1 9a", valid0, out_data0);
        end
        next_cycle();
        #1;
        total++;
        if (cnt0 !== 4'd1) begin
            bad++;
            $display("FAIL rstmid_cnt: got %0d want 1", cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gap();
        test_en_drop();
        test_wrap();
        test_rd_lat1();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
